// File: rtl/shared_iface_arbiter.sv
// shared_iface_arbiter: round-robin owner of one shared interface among NREQ requesters,
// with grant/hold/release sequencing and a bounded hold time.
module shared_iface_arbiter #(
   parameter int NREQ     = 4,
   parameter int W        = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*W-1:0]         req_x,
   output logic [NREQ-1:0]           gnt,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      bus_valid,
   output logic [W-1:0]              bus_x,
   output logic                      preempt
);
   localparam int OW = $clog2(NREQ);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HLIM = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

   typedef enum logic {IDLE, OWN} state_t;

   state_t          state_q;
   logic [NREQ-1:0] gnt_q;
   logic [OW-1:0]   owner_q, rr_q, pick_d;
   logic [HW-1:0]   hold_q;
   logic [W-1:0]    bus_x_q;
   logic            preempt_q, found_d, timeout_d, keep_d;
   logic [NREQ-1:0] cand_d;
   int              idx;

   always_comb begin
      cand_d  = req & ((state_q == OWN) ? ~(NREQ'(1) << owner_q) : '1);
      found_d = 1'b0;
      pick_d  = '0;
      idx     = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(rr_q) + i) % NREQ;
         if (!found_d && cand_d[idx]) begin
            found_d = 1'b1;
            pick_d  = OW'(idx);
         end
      end
      // >= so an owner whose count saturated while alone is still preempted once someone waits
      timeout_d = (MAX_HOLD != 0) && (state_q == OWN) && req[owner_q] && found_d && (hold_q >= HLIM);
      keep_d    = (state_q == OWN) && req[owner_q] && !timeout_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         rr_q      <= '0;
         hold_q    <= '0;
         bus_x_q   <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= timeout_d;
         if (keep_d) begin
            hold_q  <= (hold_q == HMAX) ? hold_q : hold_q + 1'b1;
            bus_x_q <= req_x[owner_q*W +: W];
         end else if (found_d) begin
            state_q <= OWN;
            owner_q <= pick_d;
            gnt_q   <= NREQ'(1) << pick_d;
            rr_q    <= (int'(pick_d) == NREQ - 1) ? '0 : pick_d + 1'b1;
            hold_q  <= '0;
            bus_x_q <= req_x[pick_d*W +: W];
         end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
         end
      end
   end

   assign gnt       = gnt_q;
   assign owner     = owner_q;
   assign bus_valid = (state_q == OWN);
   assign bus_x     = bus_x_q;
   assign preempt   = preempt_q;
endmodule

// File: tb/tb_shared_iface_arbiter.sv
// tb_shared_iface_arbiter: directed scenarios plus random traffic against a behavioural
// model of round-robin ownership with a bounded hold time.
module tb_shared_iface_arbiter;
   localparam int N  = 4;
   localparam int MH = 4;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [3:0] req = '0, req_x = '0;
   logic [3:0] gnt;
   logic [1:0] owner;
   logic       bus_valid;
   logic [0:0] bus_x;
   logic       preempt;

   int total = 0, bad = 0;
   int m_owner = 0, m_rr = 0, m_hold = 0;
   bit m_valid = 0, m_pre = 0;
   logic m_bx = 1'b0;

   shared_iface_arbiter #(.NREQ(N), .W(1), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .gnt(gnt), .owner(owner),
      .bus_valid(bus_valid), .bus_x(bus_x), .preempt(preempt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int ptr, input int excl);
      for (int k = 0; k < N; k++)
         if (((ptr + k) % N) != excl && r[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic model_edge();
      int nxt;
      if (!rst_n) begin
         m_owner = 0; m_rr = 0; m_hold = 0; m_valid = 0; m_bx = 1'b0; m_pre = 0;
         return;
      end
      nxt = rr_pick(req, m_rr, m_valid ? m_owner : -1);
      if (m_valid && req[m_owner] && !(MH != 0 && m_hold >= MH - 1 && nxt >= 0)) begin
         m_hold = (m_hold < MH) ? m_hold + 1 : MH;
         m_bx   = req_x[m_owner];
         m_pre  = 0;
      end else if (nxt >= 0) begin
         m_pre   = m_valid && req[m_owner];
         m_owner = nxt;
         m_rr    = (nxt + 1) % N;
         m_hold  = 0;
         m_valid = 1;
         m_bx    = req_x[nxt];
      end else begin
         m_valid = 0;
         m_pre   = 0;
      end
   endtask

   task automatic step(input logic r_n, input logic [3:0] r, input logic [3:0] x);
      rst_n = r_n; req = r; req_x = x;
      @(posedge clk);
      model_edge();
      #1;
      chk("gnt", 32'(gnt), m_valid ? 32'(1 << m_owner) : 32'd0);
      chk("bus_valid", 32'(bus_valid), 32'(m_valid));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("bus_x", 32'(bus_x), 32'(m_bx));
      chk("preempt", 32'(preempt), 32'(m_pre));
   endtask

   initial begin
      int eg[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
      int ep[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
      int bits[4] = '{0, 1, 1, 0};
      logic [3:0] r;
      // reset with all requesting, then first grant goes to 0
      step(0, 4'b1111, 0);
      step(0, 4'b1111, 0);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_valid", 32'(bus_valid), 0);
      chk("rst_preempt", 32'(preempt), 0);
      step(1, 4'b1111, 0);
      chk("first_gnt", 32'(gnt), 32'b0001);
      // round robin with handoffs and no idle gap
      step(1, 4'b0000, 0);
      step(1, 4'b1010, 0); chk("rr1", 32'(gnt), 32'b0010);
      step(1, 4'b1010, 0);
      step(1, 4'b1000, 0); chk("rr3", 32'(gnt), 32'b1000);
      step(1, 4'b1010, 0);
      step(1, 4'b0010, 0); chk("rr1b", 32'(gnt), 32'b0010);
      step(1, 4'b1010, 0);
      step(1, 4'b1000, 0); chk("rr3b", 32'(gnt), 32'b1000);
      // hold timeout alternates between two persistent requesters
      step(1, 4'b0000, 0);
      for (int i = 0; i < 9; i++) begin
         step(1, 4'b0011, 0);
         chk("to_gnt", 32'(gnt), 32'(eg[i]));
         chk("to_preempt", 32'(preempt), 32'(ep[i]));
      end
      // a lone owner is never preempted
      step(1, 4'b0000, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, 4'b0100, 0);
         chk("lone_gnt", 32'(gnt), 32'b0100);
         chk("lone_preempt", 32'(preempt), 0);
      end
      // data path follows the owner's field, held after release
      for (int i = 0; i < 4; i++) begin
         step(1, 4'b0100, 4'(bits[i]) << 2);
         chk("data", 32'(bus_x), 32'(bits[i]));
      end
      step(1, 4'b0000, 4'b0100);
      chk("data_hold", 32'(bus_x), 0);
      chk("data_idle", 32'(bus_valid), 0);
      // reset mid-grant
      step(1, 4'b1000, 0); chk("pre_rst", 32'(gnt), 32'b1000);
      step(0, 4'b1000, 0); chk("mid_rst", 32'(gnt), 0);
      step(1, 4'b1001, 0); chk("post_rst", 32'(gnt), 32'b0001);
      // random traffic with sticky requests so timeouts occur
      r = 4'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         step(logic'($urandom_range(0, 49) != 0), r, 4'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
